// File: rtl/avm_uart_frame_rx.sv
// avm_uart_frame_rx: Avalon-MM master polling the RS232 UART core and assembling sync-delimited sensor frames
// Optional ACK transmit after each accepted frame: define UART_FRAME_ACK_TX_EN
module avm_uart_frame_rx #(
    parameter int         N_CH        = 5,
    parameter int         CH_BYTES    = 2,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter logic [4:0] RX_BASE     = 5'd0,
    parameter logic [4:0] TX_BASE     = 5'd4,
    parameter logic [4:0] STATUS_BASE = 5'd8,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6,
    parameter logic [7:0] ACK_BYTE    = 8'h06
) (
    input  logic                         avm_clk,
    input  logic                         avm_rst,
    output logic [4:0]                   avm_address,
    output logic                         avm_read,
    input  logic [31:0]                  avm_readdata,
    output logic                         avm_write,
    output logic [31:0]                  avm_writedata,
    input  logic                         avm_waitrequest,
    output logic [N_CH*8*CH_BYTES-1:0]   o_frame_data,
    output logic                         o_frame_valid,
    input  logic                         i_frame_ready,
    output logic [15:0]                  o_frame_cnt,
    output logic [15:0]                  o_drop_cnt
);
    localparam int CH_W = 8 * CH_BYTES;
    localparam int FW   = N_CH * CH_W;
    localparam int NB   = N_CH * CH_BYTES;
    localparam int BCW  = $clog2(NB + 1);

    localparam logic [2:0] S_POLL     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_OUT      = 3'd2;
`ifdef UART_FRAME_ACK_TX_EN
    localparam logic [2:0] S_ACK_POLL = 3'd3;
    localparam logic [2:0] S_ACK_TX   = 3'd4;
`endif

    logic [2:0]     state_q, state_d;
    logic           hunt_q, hunt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [FW-1:0]  shift_q, shift_d;
    logic [4:0]     addr_q, addr_d;
    logic           read_q, read_d;
    logic [FW-1:0]  data_q, data_d;
    logic           valid_q, valid_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic [15:0]    drop_cnt_q, drop_cnt_d;
    logic           rd_done;
    logic [7:0]     rx_byte;
    logic [BCW-1:0] cnt_inc;
    logic [FW-1:0]  shift_in;
    logic           unused_bits;

`ifdef UART_FRAME_ACK_TX_EN
    logic           write_q, write_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           wr_done;
    assign wr_done       = write_q && !avm_waitrequest;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
    assign unused_bits   = ^avm_readdata[31:8];
`else
    assign avm_write     = 1'b0;
    assign avm_writedata = 32'd0;
    assign unused_bits   = ^{avm_readdata[31:8], avm_readdata[TX_OK_BIT], TX_BASE, ACK_BYTE};
`endif

    assign rd_done       = read_q && !avm_waitrequest;
    assign rx_byte       = avm_readdata[7:0];
    assign cnt_inc       = byte_cnt_q + 1'b1;
    assign shift_in      = (shift_q << 8) | FW'(rx_byte);
    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign o_frame_data  = data_q;
    assign o_frame_valid = valid_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;

    // Next-state logic: the following Avalon command is chosen on the edge that completes the current one
    always_comb begin
        state_d     = state_q;
        hunt_d      = hunt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        read_d      = read_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
`ifdef UART_FRAME_ACK_TX_EN
        write_d     = write_q;
        wdata_d     = wdata_q;
`endif
        case (state_q)
            S_POLL: begin
                if (!read_q) begin
                    read_d = 1'b1;
                    addr_d = STATUS_BASE;
                end else if (rd_done && avm_readdata[RX_OK_BIT]) begin
                    state_d = S_READ;
                    addr_d  = RX_BASE;
                end
            end
            S_READ: begin
                if (rd_done) begin
                    state_d = S_POLL;
                    addr_d  = STATUS_BASE;
                    if (hunt_q) begin
                        if (rx_byte == SYNC_BYTE) begin
                            hunt_d     = 1'b0;
                            byte_cnt_d = '0;
                        end else if (drop_cnt_q != 16'hFFFF) begin
                            drop_cnt_d = drop_cnt_q + 16'd1;
                        end
                    end else begin
                        shift_d    = shift_in;
                        byte_cnt_d = cnt_inc;
                        if (cnt_inc == BCW'(NB)) begin
                            state_d    = S_OUT;
                            read_d     = 1'b0;
                            hunt_d     = 1'b1;
                            byte_cnt_d = '0;
                            data_d     = shift_in;
                            valid_d    = 1'b1;
                        end
                    end
                end
            end
            S_OUT: begin
                if (valid_q && i_frame_ready) begin
                    valid_d     = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    read_d      = 1'b1;
                    addr_d      = STATUS_BASE;
`ifdef UART_FRAME_ACK_TX_EN
                    state_d     = S_ACK_POLL;
`else
                    state_d     = S_POLL;
`endif
                end
            end
`ifdef UART_FRAME_ACK_TX_EN
            S_ACK_POLL: begin
                if (rd_done && avm_readdata[TX_OK_BIT]) begin
                    state_d = S_ACK_TX;
                    read_d  = 1'b0;
                    write_d = 1'b1;
                    addr_d  = TX_BASE;
                    wdata_d = {24'd0, ACK_BYTE};
                end
            end
            S_ACK_TX: begin
                if (wr_done) begin
                    state_d = S_POLL;
                    write_d = 1'b0;
                    read_d  = 1'b1;
                    addr_d  = STATUS_BASE;
                end
            end
`endif
            default: begin
                state_d = S_POLL;
                read_d  = 1'b1;
                addr_d  = STATUS_BASE;
`ifdef UART_FRAME_ACK_TX_EN
                write_d = 1'b0;
`endif
            end
        endcase
    end

    // State and registered Avalon outputs; reset drops strobes at once and discards any partial frame
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_q     <= S_POLL;
            hunt_q      <= 1'b1;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            addr_q      <= STATUS_BASE;
            read_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            hunt_q      <= hunt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

`ifdef UART_FRAME_ACK_TX_EN
    // ACK write strobe and data, registered like the read side
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            write_q <= 1'b0;
            wdata_q <= 32'd0;
        end else begin
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end
`endif

endmodule

// File: tb/tb_avm_uart_frame_rx.sv
// tb_avm_uart_frame_rx: directed bench with a UART-core Avalon slave model for avm_uart_frame_rx
module tb_avm_uart_frame_rx;
    logic        avm_clk = 1'b0;
    logic        avm_rst;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [79:0] o_frame_data;
    logic        o_frame_valid;
    logic        i_frame_ready;
    logic [15:0] o_frame_cnt;
    logic [15:0] o_drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int stall = 0;
    int cyc = 0;
    int status_zeros = 0;
    int txok_zeros = 0;
    int rx_reads = 0;
    int status_reads = 0;
    int status_at_write = 0;
    int write_cnt = 0;
    int unstable = 0;
    int stall_hits = 0;
    int after_write_pending = 0;
    logic [4:0]  acc_addr;
    logic        acc_rd, acc_wr;
    logic [4:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;
    logic [4:0]  after_write_addr = '0;
    logic [7:0]  s;

    avm_uart_frame_rx dut (
        .avm_clk(avm_clk),
        .avm_rst(avm_rst),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .o_frame_data(o_frame_data),
        .o_frame_valid(o_frame_valid),
        .i_frame_ready(i_frame_ready),
        .o_frame_cnt(o_frame_cnt),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 avm_clk = ~avm_clk;

    // UART core model: stalls each access for `stall` cycles, then presents data for the next rising edge
    always @(negedge avm_clk) begin
        if (avm_rst !== 1'b1 || !(avm_read === 1'b1 || avm_write === 1'b1)) begin
            avm_waitrequest = 1'b0;
            cyc = 0;
        end else begin
            if (cyc == 0) begin
                acc_addr = avm_address;
                acc_rd = avm_read;
                acc_wr = avm_write;
            end else if (avm_address !== acc_addr || avm_read !== acc_rd || avm_write !== acc_wr) begin
                unstable++;
            end
            if (cyc < stall) begin
                avm_waitrequest = 1'b1;
                cyc++;
                stall_hits++;
            end else begin
                avm_waitrequest = 1'b0;
                cyc = 0;
                if (avm_read) begin
                    if (after_write_pending != 0) begin
                        after_write_addr = avm_address;
                        after_write_pending = 0;
                    end
                    if (avm_address == 5'd8) begin
                        status_reads++;
                        s = 8'h00;
                        if (status_zeros > 0) begin
                            status_zeros--;
                        end else begin
                            s[7] = rx_q.size() > 0;
                            s[6] = txok_zeros == 0;
                            if (txok_zeros > 0) txok_zeros--;
                        end
                        avm_readdata = {24'h3C3C3C, s};
                    end else if (avm_address == 5'd0) begin
                        rx_reads++;
                        avm_readdata = {24'hC3C3C3, (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00};
                    end else begin
                        avm_readdata = 32'hDEADBEEF;
                    end
                end else begin
                    write_cnt++;
                    last_waddr = avm_address;
                    last_wdata = avm_writedata;
                    status_at_write = status_reads;
                    after_write_pending = 1;
                end
            end
        end
    end

    task automatic wait_valid(input string name);
        for (int i = 0; i < 4000 && o_frame_valid !== 1'b1; i++) @(negedge avm_clk);
        checks++;
        if (o_frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: o_frame_valid timeout, got %b want 1", name, o_frame_valid);
        end
    endtask

    task automatic push_frame(input logic [79:0] payload);
        logic [79:0] p;
        p = payload;
        rx_q.push_back(8'hA5);
        for (int i = 9; i >= 0; i--) rx_q.push_back(p[i*8 +: 8]);
    endtask

    task automatic test_reset();
        avm_rst = 1'b0;
        stall = 0;
        repeat (3) @(negedge avm_clk);
        checks++;
        if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== 5'd8 || avm_writedata !== 32'd0) begin
            errors++;
            $display("FAIL reset_avalon: rd=%b wr=%b addr=%0d wdata=%h want 0 0 8 0", avm_read, avm_write, avm_address, avm_writedata);
        end
        checks++;
        if (o_frame_valid !== 1'b0 || o_frame_data !== 80'd0) begin
            errors++;
            $display("FAIL reset_frame: valid=%b data=%h want 0 0", o_frame_valid, o_frame_data);
        end
        checks++;
        if (o_frame_cnt !== 16'd0 || o_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: frame=%0d drop=%0d want 0 0", o_frame_cnt, o_drop_cnt);
        end
        stall = 100;
        avm_rst = 1'b1;
        for (int i = 0; i < 20 && avm_read !== 1'b1; i++) @(negedge avm_clk);
        checks++;
        if (avm_read !== 1'b1 || avm_address !== 5'd8) begin
            errors++;
            $display("FAIL first_cmd: rd=%b addr=%0d want 1 8", avm_read, avm_address);
        end
        repeat (3) @(negedge avm_clk);
        #2 avm_rst = 1'b0;
        #1;
        checks++;
        if (avm_read !== 1'b0 || avm_address !== 5'd8) begin
            errors++;
            $display("FAIL async_reset: rd=%b addr=%0d want 0 8", avm_read, avm_address);
        end
        @(negedge avm_clk);
        stall = 0;
        #2 avm_rst = 1'b1;
        for (int i = 0; i < 20 && avm_read !== 1'b1; i++) @(negedge avm_clk);
        checks++;
        if (avm_read !== 1'b1 || avm_address !== 5'd8) begin
            errors++;
            $display("FAIL cmd_after_reset: rd=%b addr=%0d want 1 8", avm_read, avm_address);
        end
    endtask

    task automatic test_basic_frame();
        int n;
        logic [79:0] d;
        i_frame_ready = 1'b1;
        status_zeros = 3;
        push_frame(80'h0102030405060708090A);
        wait_valid("basic");
        d = o_frame_data;
        n = 0;
        while (o_frame_valid === 1'b1 && n < 100) begin
            n++;
            @(negedge avm_clk);
        end
        checks++;
        if (d !== 80'h0102030405060708090A) begin
            errors++;
            $display("FAIL basic_data: got %h want 0102030405060708090a", d);
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL basic_valid_len: got %0d cycles want 1", n);
        end
        checks++;
        if (o_frame_cnt !== 16'd1 || o_drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL basic_counters: frame=%0d drop=%0d want 1 0", o_frame_cnt, o_drop_cnt);
        end
    endtask

    task automatic test_hunt();
        logic [79:0] d;
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        push_frame(80'h5AA5C33C00FFA501807E);
        wait_valid("hunt");
        d = o_frame_data;
        @(negedge avm_clk);
        checks++;
        if (d !== 80'h5AA5C33C00FFA501807E) begin
            errors++;
            $display("FAIL hunt_data: got %h want 5aa5c33c00ffa501807e", d);
        end
        checks++;
        if (o_drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL hunt_drop: got %0d want 2", o_drop_cnt);
        end
        checks++;
        if (o_frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL hunt_frames: got %0d want 2", o_frame_cnt);
        end
    endtask

    task automatic test_stall();
        logic [79:0] d;
        unstable = 0;
        stall_hits = 0;
        stall = 4;
        push_frame(80'h0102030405060708090A);
        wait_valid("stall");
        d = o_frame_data;
        @(negedge avm_clk);
        stall = 0;
        checks++;
        if (d !== 80'h0102030405060708090A) begin
            errors++;
            $display("FAIL stall_data: got %h want 0102030405060708090a", d);
        end
        checks++;
        if (unstable != 0 || stall_hits < 88) begin
            errors++;
            $display("FAIL stall_stable: unstable=%0d stalled=%0d want 0 and >=88", unstable, stall_hits);
        end
        checks++;
        if (o_frame_cnt !== 16'd3 || o_drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stall_counters: frame=%0d drop=%0d want 3 2", o_frame_cnt, o_drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [79:0] d;
        int r0, lost;
        i_frame_ready = 1'b0;
        push_frame(80'hFEDCBA98765432100123);
        wait_valid("backpressure");
        d = o_frame_data;
        r0 = rx_reads;
        rx_q.push_back(8'h77);
        lost = 0;
        repeat (20) begin
            @(negedge avm_clk);
            if (o_frame_valid !== 1'b1 || o_frame_data !== d || avm_read !== 1'b0) lost++;
        end
        checks++;
        if (lost != 0 || d !== 80'hFEDCBA98765432100123) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles data=%h want 0 fedcba98765432100123", lost, d);
        end
        checks++;
        if (rx_reads != r0) begin
            errors++;
            $display("FAIL bp_no_read: rx reads %0d want %0d", rx_reads, r0);
        end
        checks++;
        if (o_frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL bp_cnt_hold: got %0d want 3", o_frame_cnt);
        end
        i_frame_ready = 1'b1;
        @(negedge avm_clk);
        checks++;
        if (o_frame_valid !== 1'b0 || o_frame_cnt !== 16'd4) begin
            errors++;
            $display("FAIL bp_accept: valid=%b frame=%0d want 0 4", o_frame_valid, o_frame_cnt);
        end
        repeat (30) @(negedge avm_clk);
        checks++;
        if (o_frame_cnt !== 16'd4 || o_frame_valid !== 1'b0 || o_drop_cnt !== 16'd3) begin
            errors++;
            $display("FAIL ready_idle: frame=%0d valid=%b drop=%0d want 4 0 3", o_frame_cnt, o_frame_valid, o_drop_cnt);
        end
    endtask

`ifdef UART_FRAME_ACK_TX_EN
    task automatic test_ack();
        int w0, s0;
        i_frame_ready = 1'b1;
        push_frame(80'h00112233445566778899);
        wait_valid("ack");
        txok_zeros = 2;
        w0 = write_cnt;
        s0 = status_reads;
        for (int i = 0; i < 200 && write_cnt == w0; i++) @(negedge avm_clk);
        repeat (20) @(negedge avm_clk);
        checks++;
        if (write_cnt - w0 != 1) begin
            errors++;
            $display("FAIL ack_count: got %0d writes want 1", write_cnt - w0);
        end
        checks++;
        if (last_waddr !== 5'd4 || last_wdata !== 32'h00000006) begin
            errors++;
            $display("FAIL ack_write: addr=%0d data=%h want 4 00000006", last_waddr, last_wdata);
        end
        checks++;
        if (status_at_write - s0 != 3) begin
            errors++;
            $display("FAIL ack_txok_wait: %0d status reads before write want 3", status_at_write - s0);
        end
        checks++;
        if (after_write_addr !== 5'd8 || o_frame_cnt !== 16'd5) begin
            errors++;
            $display("FAIL ack_resume: next addr=%0d frames=%0d want 8 5", after_write_addr, o_frame_cnt);
        end
    endtask
`else
    task automatic test_no_write();
        checks++;
        if (write_cnt != 0 || avm_write !== 1'b0 || avm_writedata !== 32'd0) begin
            errors++;
            $display("FAIL no_write: writes=%0d wr=%b wdata=%h want 0 0 0", write_cnt, avm_write, avm_writedata);
        end
    endtask
`endif

    initial begin
        i_frame_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_hunt();
        test_stall();
        test_backpressure();
`ifdef UART_FRAME_ACK_TX_EN
        test_ack();
`else
        test_no_write();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
